// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Staged reset-release controller. Holds every downstream reset domain in
// reset after POR, then releases the domains in ascending index order. Each
// release waits a fixed delay and then waits for the current domain to
// acknowledge with ready, up to a timeout. A software or watchdog reset
// request re-asserts the released domains in descending order and restarts
// the hold phase.
//
// Ports
//   clk           sequencer clock
//   reset_n       asynchronous active-low reset (POR output)
//   reset_req     asynchronous active-high reset request, double-flop synchronised
//   domain_ready  per-domain "out of reset and alive" acknowledge, clk-synchronous
//   domain_reset  registered active-high reset, one bit per domain
//   seq_busy      high while any domain is in reset or sequencing is in progress
//   seq_done      high once all domains are released and acknowledged
//   timeout_err   sticky: a domain missed its ready acknowledge window
//   seq_state     current FSM state (debug visibility)
//
// Handshake: domain_ready is a level qualifier, not valid/ready. It is sampled
// only for the domain that was released most recently, on every clock edge
// once the release delay for that domain has expired. A high sample moves the
// sequence on at that same edge; no sample is stored.

module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_COUNT     = 8,
  parameter int DEASSERT_DELAY = 16,
  parameter int ASSERT_DELAY   = 4,
  parameter int READY_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [2:0]             seq_state
);

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ASSERT = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter, wide enough for the largest of the four intervals.
  localparam int MAX_CNT = max2(max2(HOLD_COUNT, DEASSERT_DELAY),
                                max2(ASSERT_DELAY, READY_TIMEOUT));
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Terminal counts: the counter starts at 0 on the edge that enters a state,
  // so an interval of K cycles ends on the edge where the counter holds K-1.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_COUNT - 1);
  localparam logic [CW-1:0] DD_LAST   = CW'(DEASSERT_DELAY - 1);
  localparam logic [CW-1:0] AD_LAST   = CW'(ASSERT_DELAY - 1);
  localparam logic [CW-1:0] RT_LAST   = CW'(READY_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;      // highest released domain (or next to assert)
  logic          req_meta;
  logic          req_sync;
  logic          ready_cur;
  logic          step;     // advance to the next domain (or to DONE) this edge
  logic          timed_out;

  assign seq_state = state;

  // The delay expiry edge already samples ready, so a ready that is high in
  // time costs no extra cycle, and a late one costs exactly its lateness.
  always_comb begin
    ready_cur = domain_ready[idx];
    step      = 1'b0;
    timed_out = 1'b0;
    if (state == S_DELAY) begin
      step = (cnt == DD_LAST) && ready_cur;
    end else if (state == S_WAIT) begin
      step      = ready_cur || (cnt == RT_LAST);
      timed_out = !ready_cur && (cnt == RT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_HOLD;
      cnt          <= '0;
      idx          <= '0;
      req_meta     <= 1'b0;
      req_sync     <= 1'b0;
      domain_reset <= '1;
      seq_busy     <= 1'b1;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req_meta <= reset_req;
      req_sync <= req_meta;

      case (state)
        S_HOLD: begin
          idx <= '0;
          if (req_sync) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            domain_reset[0] <= 1'b0;
            cnt             <= '0;
            state           <= S_DELAY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DELAY, S_WAIT, S_DONE: begin
          if (req_sync) begin
            // Entry edge asserts the highest released domain. With only
            // domain 0 released that is also the last assertion.
            domain_reset[idx] <= 1'b1;
            cnt               <= '0;
            seq_done          <= 1'b0;
            seq_busy          <= 1'b1;
            if (idx == '0) begin
              state       <= S_HOLD;
              timeout_err <= 1'b0;
            end else begin
              state <= S_ASSERT;
            end
          end else if (step) begin
            cnt <= '0;
            if (timed_out) timeout_err <= 1'b1;
            if (idx == IDX_LAST) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
            end else begin
              domain_reset[idx + 1'b1] <= 1'b0;
              idx                      <= idx + 1'b1;
              state                    <= S_DELAY;
            end
          end else if ((state == S_DELAY) && (cnt == DD_LAST)) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (state != S_DONE) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_ASSERT: begin
          // Requests are ignored here; the descending order always completes.
          if (cnt == AD_LAST) begin
            cnt                      <= '0;
            domain_reset[idx - 1'b1] <= 1'b1;
            idx                      <= idx - 1'b1;
            if (idx == IDX_ONE) begin
              state       <= S_HOLD;
              timeout_err <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state        <= S_HOLD;
          cnt          <= '0;
          idx          <= '0;
          domain_reset <= '1;
          seq_busy     <= 1'b1;
          seq_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with default parameters. Edge numbers in
// the steps below are relative to the most recent reset release: edge 1 is the
// first rising clk edge with reset_n high. Outputs are sampled 1 time unit
// after the rising edge.

module tb_reset_sequencer;

  localparam int N = 4;

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ASSERT = 3'd4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         reset_req;
  logic [N-1:0] domain_ready;
  logic [N-1:0] domain_reset;
  logic         seq_busy;
  logic         seq_done;
  logic         timeout_err;
  logic [2:0]   seq_state;

  int    edge_cnt  = 0;
  int    t0        = 0;
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  string scen      = "init";

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .HOLD_COUNT    (8),
    .DEASSERT_DELAY(16),
    .ASSERT_DELAY  (4),
    .READY_TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reset_req   (reset_req),
    .domain_ready(domain_ready),
    .domain_reset(domain_reset),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .seq_state   (seq_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic goto_edge(input int n);
    while (edge_cnt < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse reset_n between clock edges and restart relative edge numbering.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    t0 = edge_cnt;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s %s observed=%0h expected=%0h", scen, tag, obs, exp);
  endtask

  task automatic chk_dr(input int n, input logic [N-1:0] exp);
    goto_edge(n);
    check($sformatf("domain_reset@%0d", n), 32'(domain_reset), 32'(exp));
  endtask

  // ---------------- directed steps ----------------
  initial begin
    reset_n      = 1'b0;
    reset_req    = 1'b0;
    domain_ready = 4'b1111;

    // Reset values.
    scen = "reset";
    #12;
    check("domain_reset", 32'(domain_reset), 32'hF);
    check("seq_busy", 32'(seq_busy), 32'd1);
    check("seq_done", 32'(seq_done), 32'd0);
    check("timeout_err", 32'(timeout_err), 32'd0);
    check("state", 32'(seq_state), 32'(S_HOLD));
    #1;
    reset_n = 1'b1;
    t0 = edge_cnt;

    // Power-up, ready tied high.
    scen = "powerup";
    chk_dr(7, 4'b1111);
    chk_dr(8, 4'b1110);
    chk_dr(23, 4'b1110);
    chk_dr(24, 4'b1100);
    chk_dr(40, 4'b1000);
    chk_dr(55, 4'b1000);
    chk_dr(56, 4'b0000);
    check("busy@56", 32'(seq_busy), 32'd1);
    goto_edge(71);
    check("done@71", 32'(seq_done), 32'd0);
    goto_edge(72);
    check("done@72", 32'(seq_done), 32'd1);
    check("busy@72", 32'(seq_busy), 32'd0);
    check("timeout_err@72", 32'(timeout_err), 32'd0);
    check("state@72", 32'(seq_state), 32'(S_DONE));

    // Three-cycle reset_req pulse while in DONE, high at edges 75..77 (N=75).
    scen = "req_done";
    goto_edge(74);
    reset_req = 1'b1;
    chk_dr(76, 4'b0000);
    check("done@76", 32'(seq_done), 32'd1);
    chk_dr(77, 4'b1000);
    reset_req = 1'b0;
    check("done@77", 32'(seq_done), 32'd0);
    check("busy@77", 32'(seq_busy), 32'd1);
    check("state@77", 32'(seq_state), 32'(S_ASSERT));
    chk_dr(80, 4'b1000);
    chk_dr(81, 4'b1100);
    chk_dr(85, 4'b1110);
    chk_dr(88, 4'b1110);
    chk_dr(89, 4'b1111);
    check("state@89", 32'(seq_state), 32'(S_HOLD));
    chk_dr(96, 4'b1111);
    chk_dr(97, 4'b1110);
    chk_dr(113, 4'b1100);
    chk_dr(129, 4'b1000);
    chk_dr(145, 4'b0000);
    goto_edge(160);
    check("done@160", 32'(seq_done), 32'd0);
    goto_edge(161);
    check("done@161", 32'(seq_done), 32'd1);

    // Ready[1] held low: timeout path, then reset_n pulse mid-DELAY.
    scen = "timeout";
    domain_ready = 4'b1101;
    do_reset();
    chk_dr(24, 4'b1100);
    chk_dr(40, 4'b1100);
    check("state@40", 32'(seq_state), 32'(S_WAIT));
    chk_dr(103, 4'b1100);
    check("timeout_err@103", 32'(timeout_err), 32'd0);
    chk_dr(104, 4'b1000);
    check("timeout_err@104", 32'(timeout_err), 32'd1);
    chk_dr(110, 4'b1000);
    check("state@110", 32'(seq_state), 32'(S_DELAY));

    scen = "async_reset";
    #2;
    reset_n = 1'b0;
    #1;
    check("domain_reset", 32'(domain_reset), 32'hF);
    check("seq_busy", 32'(seq_busy), 32'd1);
    check("seq_done", 32'(seq_done), 32'd0);
    check("timeout_err", 32'(timeout_err), 32'd0);
    check("state", 32'(seq_state), 32'(S_HOLD));
    #1;
    reset_n = 1'b1;
    t0 = edge_cnt;

    // Restart timing, ready[1] rises in time for edge 50.
    scen = "late_ready";
    chk_dr(7, 4'b1111);
    chk_dr(8, 4'b1110);
    chk_dr(24, 4'b1100);
    chk_dr(49, 4'b1100);
    domain_ready = 4'b1111;
    chk_dr(50, 4'b1000);
    check("timeout_err@50", 32'(timeout_err), 32'd0);
    chk_dr(66, 4'b0000);
    goto_edge(82);
    check("done@82", 32'(seq_done), 32'd1);

    // reset_req high at edge 30 with domains 0 and 1 released.
    scen = "req_mid";
    do_reset();
    goto_edge(29);
    reset_req = 1'b1;
    goto_edge(30);
    reset_req = 1'b0;
    chk_dr(31, 4'b1100);
    chk_dr(32, 4'b1110);
    check("state@32", 32'(seq_state), 32'(S_ASSERT));
    chk_dr(35, 4'b1110);
    chk_dr(36, 4'b1111);
    check("state@36", 32'(seq_state), 32'(S_HOLD));
    chk_dr(40, 4'b1111);
    chk_dr(43, 4'b1111);
    chk_dr(44, 4'b1110);

    // reset_req held high for 100 cycles (edges 51..150), domain 0 in DELAY.
    scen = "req_held";
    goto_edge(50);
    reset_req = 1'b1;
    chk_dr(52, 4'b1110);
    chk_dr(53, 4'b1111);
    check("state@53", 32'(seq_state), 32'(S_HOLD));
    chk_dr(100, 4'b1111);
    check("busy@100", 32'(seq_busy), 32'd1);
    chk_dr(150, 4'b1111);
    reset_req = 1'b0;
    chk_dr(159, 4'b1111);
    check("busy@159", 32'(seq_busy), 32'd1);
    chk_dr(160, 4'b1110);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
